// File: rtl/mem_access_stage_if.sv
// Bundles the X/M inputs, the data-memory bus and the M/W outputs of the
// memory stage. The master modport is the stage itself. The slave modport
// is the surrounding pipeline and memory.
interface mem_access_stage_if #(
  parameter int ADDR_W = 12
);
  logic              xm_valid;
  logic [31:0]       xm_ins;
  logic [31:0]       xm_o;
  logic [31:0]       xm_b;
  logic              xm_ovf;

  logic              dmem_req;
  logic              dmem_we;
  logic [ADDR_W-1:0] dmem_addr;
  logic [31:0]       dmem_wdata;
  logic [31:0]       dmem_rdata;
  logic              dmem_ack;

  logic              mw_valid;
  logic [31:0]       mw_ins;
  logic [31:0]       mw_o;
  logic [31:0]       mw_d;
  logic              mw_ovf;
  logic              mem_stall;
  logic              bus_err;

  modport master (
    input  xm_valid, xm_ins, xm_o, xm_b, xm_ovf, dmem_rdata, dmem_ack,
    output dmem_req, dmem_we, dmem_addr, dmem_wdata,
    output mw_valid, mw_ins, mw_o, mw_d, mw_ovf, mem_stall, bus_err
  );

  modport slave (
    output xm_valid, xm_ins, xm_o, xm_b, xm_ovf, dmem_rdata, dmem_ack,
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
    input  mw_valid, mw_ins, mw_o, mw_d, mw_ovf, mem_stall, bus_err
  );
endinterface

// File: rtl/mem_access_stage.sv
// Memory stage of the 5-stage pipeline. ALU results pass through in one cycle.
// Loads and stores run a req/ack handshake on the data memory and stall
// the upstream pipe while they wait. A timeout forces completion with an error.
module mem_access_stage #(
  parameter int         ADDR_W  = 12,
  parameter int         TIMEOUT = 15,
  parameter logic [4:0] OP_LW   = 5'b01000,
  parameter logic [4:0] OP_SW   = 5'b00111
) (
  input logic                clk,
  input logic                reset_n,
  mem_access_stage_if.master bus
);
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t           state, state_next;
  logic [CNT_W-1:0] count, count_next;
  logic [31:0]      cap_ins, cap_ins_next;
  logic [31:0]      cap_o, cap_o_next;
  logic [31:0]      cap_b, cap_b_next;
  logic             cap_we, cap_we_next;
  logic             cap_ovf, cap_ovf_next;
  logic             mw_valid, mw_valid_next;
  logic [31:0]      mw_ins, mw_ins_next;
  logic [31:0]      mw_o, mw_o_next;
  logic [31:0]      mw_d, mw_d_next;
  logic             mw_ovf, mw_ovf_next;
  logic             bus_err, bus_err_next;
  logic             mem_stall;
  logic             dmem_req;
  logic             is_mem;
  logic             last_cycle;

  assign is_mem = bus.xm_valid &
                  ((bus.xm_ins[31:27] == OP_LW) | (bus.xm_ins[31:27] == OP_SW));
  assign last_cycle = (count == CNT_W'(TIMEOUT - 1));

  // Register the FSM state, the captured access and the M/W outputs.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state    <= IDLE;
      count    <= '0;
      cap_ins  <= '0;
      cap_o    <= '0;
      cap_b    <= '0;
      cap_we   <= 1'b0;
      cap_ovf  <= 1'b0;
      mw_valid <= 1'b0;
      mw_ins   <= '0;
      mw_o     <= '0;
      mw_d     <= '0;
      mw_ovf   <= 1'b0;
      bus_err  <= 1'b0;
    end else begin
      state    <= state_next;
      count    <= count_next;
      cap_ins  <= cap_ins_next;
      cap_o    <= cap_o_next;
      cap_b    <= cap_b_next;
      cap_we   <= cap_we_next;
      cap_ovf  <= cap_ovf_next;
      mw_valid <= mw_valid_next;
      mw_ins   <= mw_ins_next;
      mw_o     <= mw_o_next;
      mw_d     <= mw_d_next;
      mw_ovf   <= mw_ovf_next;
      bus_err  <= bus_err_next;
    end
  end

  // Next-state, retire values and stall/request decode. Ack beats timeout.
  always_comb begin
    state_next    = state;
    count_next    = count;
    cap_ins_next  = cap_ins;
    cap_o_next    = cap_o;
    cap_b_next    = cap_b;
    cap_we_next   = cap_we;
    cap_ovf_next  = cap_ovf;
    mw_valid_next = mw_valid;
    mw_ins_next   = mw_ins;
    mw_o_next     = mw_o;
    mw_d_next     = mw_d;
    mw_ovf_next   = mw_ovf;
    bus_err_next  = bus_err;
    mem_stall     = 1'b0;
    dmem_req      = 1'b0;

    case (state)
      IDLE: begin
        if (is_mem) begin
          mem_stall     = 1'b1;
          cap_ins_next  = bus.xm_ins;
          cap_o_next    = bus.xm_o;
          cap_b_next    = bus.xm_b;
          cap_ovf_next  = bus.xm_ovf;
          cap_we_next   = (bus.xm_ins[31:27] == OP_SW);
          count_next    = '0;
          state_next    = ACCESS;
          mw_valid_next = 1'b0;
          mw_ins_next   = '0;
        end else begin
          mw_valid_next = bus.xm_valid;
          mw_ins_next   = bus.xm_valid ? bus.xm_ins : 32'd0;
          mw_o_next     = bus.xm_o;
          mw_ovf_next   = bus.xm_ovf;
          mw_d_next     = '0;
        end
      end
      ACCESS: begin
        dmem_req  = 1'b1;
        mem_stall = !bus.dmem_ack & !last_cycle;
        if (bus.dmem_ack) begin
          state_next    = IDLE;
          mw_valid_next = 1'b1;
          mw_ins_next   = cap_ins;
          mw_o_next     = cap_o;
          mw_ovf_next   = cap_ovf;
          mw_d_next     = cap_we ? 32'd0 : bus.dmem_rdata;
        end else if (last_cycle) begin
          state_next    = IDLE;
          mw_valid_next = 1'b1;
          mw_ins_next   = cap_ins;
          mw_o_next     = cap_o;
          mw_ovf_next   = 1'b1;
          mw_d_next     = '0;
          bus_err_next  = 1'b1;
        end else begin
          count_next    = count + CNT_W'(1);
          mw_valid_next = 1'b0;
          mw_ins_next   = '0;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign bus.dmem_req   = dmem_req;
  assign bus.dmem_we    = cap_we;
  assign bus.dmem_addr  = cap_o[ADDR_W-1:0];
  assign bus.dmem_wdata = cap_b;
  assign bus.mw_valid   = mw_valid;
  assign bus.mw_ins     = mw_ins;
  assign bus.mw_o       = mw_o;
  assign bus.mw_d       = mw_d;
  assign bus.mw_ovf     = mw_ovf;
  assign bus.mem_stall  = mem_stall;
  assign bus.bus_err    = bus_err;
endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage. Stimulus pushes expected retirements into a
// scoreboard queue. A monitor pops an entry on every mw_valid and compares it.
module tb_mem_access_stage;
  localparam int ADDR_W  = 12;
  localparam int TIMEOUT = 15;

  localparam logic [31:0] ADDI_INS = 32'h2840_0005;
  localparam logic [31:0] ADD_INS  = 32'h0812_3000;
  localparam logic [31:0] LW_INS   = 32'h4040_0010;
  localparam logic [31:0] SW_INS   = 32'h3840_0020;

  typedef struct {
    logic [31:0] ins;
    logic [31:0] o;
    logic [31:0] d;
    logic        ovf;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  mem_access_stage_if #(.ADDR_W(ADDR_W)) bus ();

  mem_access_stage #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );

  // Count rising edges so retirements can be checked against their latency.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    end
  endtask

  function automatic exp_t mkExp(input logic [31:0] ins, input logic [31:0] o,
                                 input logic [31:0] d, input logic ovf, input int c);
    exp_t e;
    e.ins = ins;
    e.o   = o;
    e.d   = d;
    e.ovf = ovf;
    e.cyc = c;
    return e;
  endfunction

  task automatic applyStimulus(input logic v, input logic [31:0] ins, input logic [31:0] o,
                               input logic [31:0] b, input logic ovf);
    bus.xm_valid = v;
    bus.xm_ins   = ins;
    bus.xm_o     = o;
    bus.xm_b     = b;
    bus.xm_ovf   = ovf;
  endtask

  // Monitor: every retirement must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    if (bus.mw_valid === 1'b1) begin
      if (sb.size() == 0) begin
        checkOutput("unexpected mw_valid", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        checkOutput("mw_ins", bus.mw_ins, e.ins);
        checkOutput("mw_o", bus.mw_o, e.o);
        checkOutput("mw_d", bus.mw_d, e.d);
        checkOutput("mw_ovf", 32'(bus.mw_ovf), 32'(e.ovf));
        checkOutput("retire cycle", cyc, e.cyc);
      end
    end
  end

  task automatic runAlu(input logic [31:0] ins, input logic [31:0] o, input logic ovf);
    @(posedge clk); #1;
    applyStimulus(1'b1, ins, o, 32'h0, ovf);
    sb.push_back(mkExp(ins, o, 32'd0, ovf, cyc + 1));
    @(negedge clk);
    checkOutput("alu mem_stall", 32'(bus.mem_stall), 32'd0);
    @(posedge clk); #1;
    applyStimulus(1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
    @(negedge clk);
    checkOutput("alu mem_stall next", 32'(bus.mem_stall), 32'd0);
  endtask

  // ack_at: ACCESS cycle (1-based) carrying the ack, 0 for no ack.
  task automatic runMem(input logic [31:0] ins, input logic [31:0] o, input logic [31:0] b,
                        input int ack_at, input logic [31:0] rdata, input logic we,
                        input logic [31:0] exp_d, input logic exp_ovf, input int exp_cycles);
    int c;
    int req_n;
    int stall_n;
    c = (ack_at != 0) ? ack_at : TIMEOUT;
    req_n = 0;
    stall_n = 0;
    @(posedge clk); #1;
    applyStimulus(1'b1, ins, o, b, 1'b0);
    sb.push_back(mkExp(ins, o, exp_d, exp_ovf, cyc + c + 1));
    for (int j = 0; j <= TIMEOUT + 2; j++) begin
      bus.dmem_ack   = (ack_at != 0) && (j == ack_at);
      bus.dmem_rdata = (j == ack_at) ? rdata : (32'hBAD0_0000 | 32'(j));
      @(negedge clk);
      if (bus.mem_stall === 1'b1) stall_n++;
      if (bus.dmem_req === 1'b1) begin
        req_n++;
        checkOutput("dmem_addr", 32'(bus.dmem_addr), 32'(o[ADDR_W-1:0]));
        checkOutput("dmem_we", 32'(bus.dmem_we), 32'(we));
        if (we) checkOutput("dmem_wdata", bus.dmem_wdata, b);
      end
      @(posedge clk); #1;
      if (j == c) applyStimulus(1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
    end
    bus.dmem_ack = 1'b0;
    checkOutput("dmem_req cycles", req_n, exp_cycles);
    checkOutput("mem_stall cycles", stall_n, exp_cycles);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Reset held two cycles with a valid addi on X/M.
    applyStimulus(1'b1, ADDI_INS, 32'h7, 32'h0, 1'b0);
    bus.dmem_ack   = 1'b0;
    bus.dmem_rdata = 32'h0;
    reset_n = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    checkOutput("reset mw_valid", 32'(bus.mw_valid), 32'd0);
    checkOutput("reset mw_ins", bus.mw_ins, 32'd0);
    checkOutput("reset mw_o", bus.mw_o, 32'd0);
    checkOutput("reset mw_d", bus.mw_d, 32'd0);
    checkOutput("reset mw_ovf", 32'(bus.mw_ovf), 32'd0);
    checkOutput("reset bus_err", 32'(bus.bus_err), 32'd0);
    checkOutput("reset mem_stall", 32'(bus.mem_stall), 32'd0);
    checkOutput("reset dmem_req", 32'(bus.dmem_req), 32'd0);
    @(posedge clk); #1;
    applyStimulus(1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
    reset_n = 1'b1;

    // ALU pass-through.
    runAlu(ADD_INS, 32'h1234, 1'b1);
    runAlu(ADDI_INS, 32'hFFFF_0001, 1'b0);

    // Load acked on the third ACCESS cycle.
    runMem(LW_INS, 32'h10, 32'h0, 3, 32'hDEAD_BEEF, 1'b0, 32'hDEAD_BEEF, 1'b0, 3);
    // Store acked on the first ACCESS cycle.
    runMem(SW_INS, 32'h20, 32'h55, 1, 32'h1111_2222, 1'b1, 32'd0, 1'b0, 1);

    // Load with no ack times out and sets the sticky error.
    runMem(LW_INS, 32'h30, 32'h0, 0, 32'h0, 1'b0, 32'd0, 1'b1, TIMEOUT);
    checkOutput("bus_err after timeout", 32'(bus.bus_err), 32'd1);
    // Ack in the final allowed cycle wins over the timeout.
    runMem(LW_INS, 32'h44, 32'h0, TIMEOUT, 32'hCAFE_F00D, 1'b0, 32'hCAFE_F00D, 1'b0, TIMEOUT);
    checkOutput("bus_err sticky", 32'(bus.bus_err), 32'd1);

    // Reset during the second ACCESS cycle, then a stray ack while idle.
    @(posedge clk); #1;
    applyStimulus(1'b1, LW_INS, 32'h50, 32'h0, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset_n = 1'b0;
    applyStimulus(1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
    @(negedge clk);
    checkOutput("mid reset dmem_req still up", 32'(bus.dmem_req), 32'd1);
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(negedge clk);
    checkOutput("post reset dmem_req", 32'(bus.dmem_req), 32'd0);
    checkOutput("post reset bus_err", 32'(bus.bus_err), 32'd0);
    checkOutput("post reset mw_valid", 32'(bus.mw_valid), 32'd0);
    @(posedge clk); #1;
    bus.dmem_ack   = 1'b1;
    bus.dmem_rdata = 32'h9999_9999;
    @(posedge clk); #1;
    bus.dmem_ack = 1'b0;
    @(negedge clk);
    checkOutput("idle ack mw_valid", 32'(bus.mw_valid), 32'd0);
    checkOutput("idle ack dmem_req", 32'(bus.dmem_req), 32'd0);

    // One more ALU op after recovery.
    runAlu(ADD_INS, 32'hA5A5_0000, 1'b0);

    repeat (3) @(posedge clk);
    checkOutput("scoreboard drained", sb.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
